// File: rtl/branch_target_predictor.sv
// branch_target_predictor
//   Direct-mapped branch target buffer with per-entry saturating counters, tag
//   check and a saturating mispredict counter. Looked up combinationally by the
//   IF-stage PC, trained at the clock edge by the ID-stage resolution.
//
//   Optional feature macro: GSHARE_EN
//     When defined, a GHR_W-bit global history register is XORed into the low
//     index bits for both lookup and training, and the ports pred_ghr/upd_ghr
//     are added. When undefined, indexing uses PC bits only.
//
//   Ports:
//     clk            main clock
//     arst_n         synchronous active-low reset (despite the name)
//     en             pipeline advance; 0 freezes all state
//     if_pc          IF-stage PC to look up
//     pred_hit       valid tag match for if_pc
//     pred_taken     predict taken
//     pred_target    predicted target, 0 on a miss
//     upd_valid      ID stage holds a resolved branch/jump
//     upd_pc         PC of the resolved instruction
//     upd_taken      actual outcome
//     upd_target     actual taken target
//     upd_pred_taken prediction that was used for this instruction
//     mispredict_cnt saturating count of mispredictions
//     pred_ghr       (GSHARE_EN) current global history
//     upd_ghr        (GSHARE_EN) history the resolved instruction was predicted with
module branch_target_predictor #(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned GHR_W   = 4
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            en,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    output logic [31:0]     mispredict_cnt
`ifdef GSHARE_EN
    ,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic [GHR_W-1:0] upd_ghr
`endif
);

    localparam int unsigned IdxW = $clog2(ENTRIES);
    localparam int unsigned TagW = PC_W - IdxW - 2;

    localparam logic [CNT_W-1:0] CtrMax    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CtrWeakT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CtrWeakNt = CtrWeakT - CNT_W'(1);

    // Packed storage keeps whole-table reset a single assignment.
    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][TagW-1:0]  tag_q;
    logic [ENTRIES-1:0][PC_W-1:0]  target_q;
    logic [ENTRIES-1:0][CNT_W-1:0] ctr_q;
    logic [31:0]                   cnt_q;

    logic [IdxW-1:0]  lk_idx;
    logic [TagW-1:0]  lk_tag;
    logic [IdxW-1:0]  up_idx;
    logic [TagW-1:0]  up_tag;
    logic             up_hit;
    logic [CNT_W-1:0] up_ctr;
    logic [CNT_W-1:0] up_ctr_d;
    logic             train;
    logic             mispredict;

    // Low PC bits are word offset and never reach the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

`ifdef GSHARE_EN
    logic [GHR_W-1:0] ghr_q;
    logic [GHR_W:0]   ghr_shift;

    assign pred_ghr  = ghr_q;
    // Repair history from the resolved path; top bit of the concatenation drops off.
    assign ghr_shift = {upd_ghr, upd_taken};

    assign lk_idx = if_pc[IdxW+1:2] ^ IdxW'(ghr_q);
    assign up_idx = upd_pc[IdxW+1:2] ^ IdxW'(upd_ghr);

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            ghr_q <= '0;
        end else if (train) begin
            ghr_q <= ghr_shift[GHR_W-1:0];
        end
    end
`else
    assign lk_idx = if_pc[IdxW+1:2];
    assign up_idx = upd_pc[IdxW+1:2];
`endif

    assign lk_tag = if_pc[PC_W-1:IdxW+2];
    assign up_tag = upd_pc[PC_W-1:IdxW+2];

    // Lookup: reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = pred_hit && ctr_q[lk_idx][CNT_W-1];
        pred_target = pred_hit ? target_q[lk_idx] : '0;
    end

    assign train      = en && upd_valid;
    assign mispredict = train && (upd_pred_taken != upd_taken);
    assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_ctr     = ctr_q[up_idx];

    always_comb begin
        up_ctr_d = up_ctr;
        if (upd_taken) begin
            if (up_ctr != CtrMax) begin
                up_ctr_d = up_ctr + CNT_W'(1);
            end
        end else begin
            if (up_ctr != '0) begin
                up_ctr_d = up_ctr - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{CtrWeakNt}};
        end else if (train) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_d;
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Allocate, evicting whatever aliased into this slot.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CtrWeakT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            cnt_q <= '0;
        end else if (mispredict && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign mispredict_cnt = cnt_q;

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
Parametrised successor to the pipeline's single-table branch predictor. It is an N-entry direct-mapped branch target buffer with per-entry CNT_W-bit saturating counters, a tag check and a mispredict statistics counter. It is looked up combinationally by the IF-stage PC and trained one cycle later by the ID-stage branch/jump resolution. It drives the PC mux's prediction inputs: taken flag and target.

Parameters:
PC_W, 64, PC and target width
ENTRIES, 16, table depth; power of two, 2..256; IDX_W = log2(ENTRIES)
CNT_W, 2, saturating counter width, 1..4
GHR_W, 4, global history length; only used with GSHARE_EN; must be <= IDX_W

Ports:
clk  in  1  main clock
arst_n  in  1  reset; synchronous, active-low
en  in  1  pipeline advance (enable & !hazard); 0 freezes all state
if_pc  in  PC_W  IF-stage PC to look up
pred_hit  out  1  valid tag match for if_pc
pred_taken  out  1  predict taken
pred_target  out  PC_W  predicted target; 0 when !pred_hit
upd_valid  in  1  ID stage holds a resolved branch/jump this cycle
upd_pc  in  PC_W  PC of the resolved instruction
upd_taken  in  1  actual outcome; 1 for jumps
upd_target  in  PC_W  actual taken target
upd_pred_taken  in  1  prediction that was used for this instruction
mispredict_cnt  out  32  saturating count of mispredictions

Behaviour:
- Index = pc[IDX_W+1:2]. Tag = pc[PC_W-1:IDX_W+2].
- Each entry holds valid, tag, target and ctr.
- Lookup is purely combinational, with zero latency.
  - pred_hit = valid[i] && tag[i]==tag(if_pc).
  - pred_taken = pred_hit && ctr[i][CNT_W-1].
  - pred_target = pred_hit ? target[i] : 0.
- Synchronous reset (arst_n=0 at posedge):
  - all valid=0;
  - all ctr = 2^(CNT_W-1)-1 (weakly not-taken; 0 for CNT_W=1);
  - targets and tags = 0;
  - mispredict_cnt = 0;
  - outputs therefore read pred_hit=0, pred_taken=0, pred_target=0.
- Reset overrides en and upd_valid in the same cycle.
- Training happens at posedge when en && upd_valid. Let j = index(upd_pc).
  - Hit (valid[j] && tag match): ctr[j] increments if upd_taken, otherwise decrements, saturating at 2^CNT_W-1 and 0. target[j] = upd_target only when upd_taken.
  - Miss and upd_taken: allocate, overwriting any conflicting entry. valid=1, tag=tag(upd_pc), target=upd_target, ctr = 2^(CNT_W-1) (weakly taken).
  - Miss and !upd_taken: no table change.
- Mispredict counting:
  - Condition is en && upd_valid && (upd_pred_taken != upd_taken).
  - mispredict_cnt increments by 1 and saturates at 32'hFFFF_FFFF.
- en=0 blocks all updates. No table or counter change occurs even if upd_valid=1.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass). The new value is visible on the next cycle.
- upd_pc/if_pc bits [1:0] are ignored.

Optional Feature:
GSHARE_EN
- Defined:
  - adds a GHR_W-bit global history register, reset to 0;
  - lookup index = pc[IDX_W+1:2] XOR {0, ghr};
  - adds output pred_ghr (GHR_W) = current ghr, to be piped to ID;
  - adds input upd_ghr (GHR_W); training index = upd_pc[IDX_W+1:2] XOR {0, upd_ghr};
  - on each trained update, ghr <= {upd_ghr[GHR_W-2:0], upd_taken}, i.e. speculation is repaired from the resolved history;
  - tags are unchanged.
- Undefined: ports pred_ghr/upd_ghr do not exist and indexing is pure PC bits.

Test Plan:
- Reset then lookup: any if_pc, e.g. 0x40 -> pred_hit=0, pred_taken=0, pred_target=0, mispredict_cnt=0.
- Allocate: upd pc=0x40, taken=1, target=0x100, pred_taken=0 with en=1.
  - Next cycle, if_pc=0x40 -> hit=1, taken=1, target=0x100, mispredict_cnt=1.
  - if_pc=0x440 (same index, different tag) -> hit=0.
- Saturation, CNT_W=2 on the 0x40 entry:
  - three not-taken updates -> ctr 2→1→0→0; pred_taken=0 after the first.
  - two taken updates -> ctr 0→1→2; pred_taken=1 after the second.
- Stall: en=0 with upd_valid=1, taken=1, pc=0x80 -> no allocation (if_pc=0x80 hit=0) and mispredict_cnt unchanged.
- Same-cycle hazard: if_pc=upd_pc=0x80 allocating -> pred_hit=0 that cycle, pred_hit=1 the next.
- Synchronous reset mid-run: after allocations, arst_n=0 for one posedge with upd_valid=1 -> all entries invalid, cnt=0; arst_n deasserted without a clock edge has no effect.
